led_effect_ctrl: RTL and testbench

// - Sequences a one-hot LED chaser in the LED effect designs: left-to-right sweep, then right-to-left sweep, repeated N times.
// - Contains its own step prescaler, a counter that produces a one-cycle enable. It does not generate a derived clock.
// - The whole block runs in the clk domain.
// - The board top drives it through a start/stop/busy/done handshake and a run-time speed select.
//

---
 rtl/led_effect_ctrl.sv | 173 +++++++++++++++++
 tb/tb_led_effect_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_effect_ctrl.sv
// One-hot LED chaser: left-to-right then right-to-left sweep, repeated per run,
// stepped by an internal prescaler enable. Optional end-of-run blink: LED_BLINK_EN.
module led_effect_ctrl #(
  parameter int NUM_LED  = 8,
  parameter int TICK_DIV = 10,
  parameter int CNT_W    = 7,
  parameter int REP_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         speed,
  input  logic [REP_W-1:0]   repeat_n,
  output logic [NUM_LED-1:0] led,
  output logic               busy,
  output logic               done,
  output logic               step_tick
);

  localparam int PW = $clog2(NUM_LED);
  localparam logic [PW-1:0] POS_MAX = PW'(NUM_LED - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LR    = 3'd1,
    S_RL    = 3'd2,
`ifdef LED_BLINK_EN
    S_BLINK = 3'd3,
`endif
    S_DONE  = 3'd4
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   presc, presc_d;
  logic [PW-1:0]      pos, pos_d;
  logic [REP_W-1:0]   pass, pass_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [1:0]         speed_q, speed_d;
`ifdef LED_BLINK_EN
  logic [1:0]         blink_q, blink_d;
`endif

  logic [CNT_W-1:0]   period;
  logic               last;
  logic [NUM_LED-1:0] one_hot;

  assign period  = CNT_W'(TICK_DIV) << speed_q;
  assign last    = (presc == period - CNT_W'(1));
  assign one_hot = {{(NUM_LED-1){1'b0}}, 1'b1} << pos;

  // NOTE: every output and next-state value gets a default before the case,
  // so no path through this block can leave a variable unassigned (no latches).
  always_comb begin
    state_d   = state;
    presc_d   = presc;
    pos_d     = pos;
    pass_d    = pass;
    rep_d     = rep_q;
    speed_d   = speed_q;
`ifdef LED_BLINK_EN
    blink_d   = blink_q;
`endif
    led       = '0;
    busy      = 1'b1;
    done      = 1'b0;
    step_tick = 1'b0;

    case (state)
      S_IDLE: begin
        busy    = 1'b0;
        presc_d = '0;
        if (start && !stop) begin
          state_d = S_LR;
          speed_d = speed;
          rep_d   = (repeat_n == '0) ? REP_W'(1) : repeat_n;
          pass_d  = REP_W'(1);
          pos_d   = POS_MAX;
        end
      end

      S_LR: begin
        led       = one_hot;
        step_tick = last;
        presc_d   = last ? '0 : presc + 1'b1;
        if (last) begin
          // Bit 0 stays lit into RL, so the turnaround LED shows for two steps.
          if (pos == '0) state_d = S_RL;
          else           pos_d   = pos - 1'b1;
        end
      end

      S_RL: begin
        led       = one_hot;
        step_tick = last;
        presc_d   = last ? '0 : presc + 1'b1;
        if (last) begin
          if (pos != POS_MAX) begin
            pos_d = pos + 1'b1;
          end else if (pass < rep_q) begin
            // pass < rep_q guarantees the increment cannot wrap.
            pass_d  = pass + 1'b1;
            state_d = S_LR;
          end else begin
`ifdef LED_BLINK_EN
            state_d = S_BLINK;
            blink_d = '0;
`else
            state_d = S_DONE;
`endif
          end
        end
      end

`ifdef LED_BLINK_EN
      S_BLINK: begin
        led       = blink_q[0] ? '0 : '1;
        step_tick = last;
        presc_d   = last ? '0 : presc + 1'b1;
        if (last) begin
          if (blink_q == 2'd3) state_d = S_DONE;
          else                 blink_d = blink_q + 1'b1;
        end
      end
`endif

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Abort beats any step transition computed above.
    if (stop && state != S_IDLE) begin
      state_d = S_IDLE;
      presc_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  // NOTE: the asynchronous reset clears every register, including the latched
  // run settings, so nothing carries over from an interrupted run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      presc   <= '0;
      pos     <= '0;
      pass    <= '0;
      rep_q   <= '0;
      speed_q <= '0;
`ifdef LED_BLINK_EN
      blink_q <= '0;
`endif
    end else begin
      state   <= state_d;
      presc   <= presc_d;
      pos     <= pos_d;
      pass    <= pass_d;
      rep_q   <= rep_d;
      speed_q <= speed_d;
`ifdef LED_BLINK_EN
      blink_q <= blink_d;
`endif
    end
  end

endmodule

// File: tb/tb_led_effect_ctrl.sv
// Self-checking bench for led_effect_ctrl: run-length table, cycle-by-cycle
// reference model with randomized runs/aborts, and reset/stop corner cases.
module tb_led_effect_ctrl;

  localparam int N  = 4;
  localparam int TD = 2;
  localparam int CW = 7;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          stop;
  logic [1:0]    speed;
  logic [RW-1:0] repeat_n;
  logic [N-1:0]  led;
  logic          busy;
  logic          done;
  logic          step_tick;

  led_effect_ctrl #(
    .NUM_LED  (N),
    .TICK_DIV (TD),
    .CNT_W    (CW),
    .REP_W    (RW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .speed     (speed),
    .repeat_n  (repeat_n),
    .led       (led),
    .busy      (busy),
    .done      (done),
    .step_tick (step_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] led;
    logic         busy;
    logic         done;
    logic         tick;
  } obs_t;

  typedef struct {
    int spd;
    int rep;
    int done_cyc;
    int ticks;
  } vec_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  obs_t exp_q[$];
  vec_t tbl[5];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic obs_t mk(input logic [N-1:0] l, input logic b, input logic d,
                              input logic t);
    obs_t o;
    o.led  = l;
    o.busy = b;
    o.done = d;
    o.tick = t;
    return o;
  endfunction

  function automatic obs_t obs_now();
    return mk(led, busy, done, step_tick);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs for cycles 1.. of an uninterrupted run, ending with one IDLE cycle.
  task automatic build_model(input int spd, input int rep);
    int p;
    int reps;
    int b;
    logic [N-1:0] l;
    p    = TD << spd;
    reps = (rep == 0) ? 1 : rep;
    exp_q.delete();
    for (int ps = 0; ps < reps; ps++)
      for (int s = 0; s < 2 * N; s++) begin
        b = (s < N) ? (N - 1 - s) : (s - N);
        l = N'(1) << b;
        for (int c = 0; c < p; c++) exp_q.push_back(mk(l, 1'b1, 1'b0, c == p - 1));
      end
`ifdef LED_BLINK_EN
    for (int k = 0; k < 4; k++) begin
      l = (k % 2 == 0) ? {N{1'b1}} : {N{1'b0}};
      for (int c = 0; c < p; c++) exp_q.push_back(mk(l, 1'b1, 1'b0, c == p - 1));
    end
`endif
    exp_q.push_back(mk('0, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0));
  endtask

  // One run compared every cycle; stop_at>0 raises stop during that cycle.
  task automatic run(input string tag, input int spd, input int rep, input int stop_at);
    int s;
    int last_i;
    build_model(spd, rep);
    s = stop_at;
    if (s > exp_q.size() - 1) s = 0;
    if (s > 0) begin
      while (exp_q.size() > s) void'(exp_q.pop_back());
      exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0));
    end
    last_i   = exp_q.size() - 1;
    speed    = 2'(spd);
    repeat_n = RW'(rep);
    start    = 1'b1;
    stop     = 1'b0;
    tick();
    for (int i = 0; i <= last_i; i++) begin
      check($sformatf("%s cyc%0d {led,busy,done,tick}", tag, i + 1),
            int'(obs_now()), int'(exp_q[i]));
      stop     = (i + 1 == s);
      speed    = 2'($urandom_range(0, 3));
      repeat_n = RW'($urandom_range(0, 15));
      start    = (i < last_i) && ($urandom_range(0, 3) == 0);
    tick();
    end
    start    = 1'b0;
    stop     = 1'b0;
    speed    = '0;
    repeat_n = '0;
  endtask

  task automatic measure(input int idx);
    int c;
    int ticks;
    int dones;
    int done_cyc;
    int exp_done;
    int exp_ticks;
    exp_done  = tbl[idx].done_cyc;
    exp_ticks = tbl[idx].ticks;
`ifdef LED_BLINK_EN
    exp_done  = exp_done + 4 * (TD << tbl[idx].spd);
    exp_ticks = exp_ticks + 4;
`endif
    speed    = 2'(tbl[idx].spd);
    repeat_n = RW'(tbl[idx].rep);
    start    = 1'b1;
    tick();
    start    = 1'b0;
    c = 1; ticks = 0; dones = 0; done_cyc = -1;
    while (busy && c <= 2000) begin
      if (step_tick) ticks++;
      if (done) begin
        dones++;
        done_cyc = c;
      end
      tick();
      c++;
    end
    check($sformatf("tbl%0d done cycle", idx), done_cyc, exp_done);
    check($sformatf("tbl%0d idle cycle", idx), c, exp_done + 1);
    check($sformatf("tbl%0d step_tick count", idx), ticks, exp_ticks);
    check($sformatf("tbl%0d done pulses", idx), dones, 1);
  endtask

  initial begin
    tbl[0] = '{spd: 0, rep: 1, done_cyc: 17,  ticks: 8};
    tbl[1] = '{spd: 2, rep: 0, done_cyc: 65,  ticks: 8};
    tbl[2] = '{spd: 0, rep: 3, done_cyc: 49,  ticks: 24};
    tbl[3] = '{spd: 1, rep: 2, done_cyc: 65,  ticks: 16};
    tbl[4] = '{spd: 3, rep: 1, done_cyc: 129, ticks: 8};

    reset = 1'b1; start = 1'b0; stop = 1'b0; speed = '0; repeat_n = '0;
    #1;
    check("reset outputs", int'(obs_now()), 0);
    start = 1'b1;
    tick();
    tick();
    check("reset held with start", int'(obs_now()), 0);
    start = 1'b0;
    reset = 1'b0;
    tick();
    check("idle after reset", int'(obs_now()), 0);

    for (int i = 0; i < 5; i++) measure(i);

    run("T1", 0, 1, 0);
    run("T4 stop", 0, 1, 5);

    start = 1'b1; stop = 1'b1;
    tick();
    check("start+stop busy", int'(busy), 0);
    check("start+stop led", int'(led), 0);
    start = 1'b0; stop = 1'b0;
    tick();
    check("start+stop stays idle", int'(obs_now()), 0);

    speed = '0; repeat_n = RW'(1); start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    #2 reset = 1'b1;
    #1;
    check("async reset mid-run", int'(obs_now()), 0);
    tick();
    reset = 1'b0;
    tick();
    check("idle after mid-run reset", int'(obs_now()), 0);
    run("T5 rerun", 0, 1, 0);

    for (int r = 0; r < 12; r++) begin
      int spd;
      int rep;
      int sa;
      spd = $urandom_range(0, 3);
      rep = $urandom_range(0, 3);
      sa  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 150) : 0;
      run($sformatf("rnd%0d s%0d r%0d stop%0d", r, spd, rep, sa), spd, rep, sa);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
